ham_secded_dec: RTL and testbench

//  Parametrised, pipelined Hamming SECDED decoder; successor to the fixed (7,4) encoder.

---
 rtl/ham_secded_dec.sv | 137 +++++++++++++
 tb/tb_ham_secded_dec.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ham_secded_dec.sv
// Two-stage pipelined extended-Hamming SECDED decoder on a valid/ready stream.
// Define HAM_ERR_CNT_EN to build the saturating SEC/DED delivery counters.
module ham_secded_dec #(
  parameter  int unsigned DATA_W = 4,
  parameter  int unsigned CNT_W  = 16,
  localparam int unsigned P_W    = (DATA_W <= 4)  ? 3 :
                                   (DATA_W <= 11) ? 4 :
                                   (DATA_W <= 26) ? 5 :
                                   (DATA_W <= 57) ? 6 : 7,
  localparam int unsigned CODE_W = DATA_W + P_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sec,
  output logic              out_ded,
  output logic [P_W-1:0]    out_syn,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  sec_cnt,
  output logic [CNT_W-1:0]  ded_cnt
);

  // Hamming position carrying data bit k (non-power-of-two positions, ascending from 3).
  function automatic int unsigned data_pos(input int unsigned k);
    int unsigned n;
    data_pos = 0;
    n = 0;
    for (int unsigned p = 3; p < CODE_W; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (n == k) data_pos = p;
        n++;
      end
    end
  endfunction

  logic              en;
  logic              s1_valid;
  logic              s1_par;
  logic [P_W-1:0]    s1_syn;
  logic [CODE_W-1:0] s1_code;
  logic [P_W-1:0]    syn_c;
  logic              par_c;
  logic [CODE_W-1:0] fixed_c;
  logic              hit_c;
  logic              sec_c;
  logic              ded_c;
  logic [DATA_W-1:0] data_c;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Syndrome is the XOR of the indices of every set Hamming position.
  always_comb begin
    syn_c = '0;
    for (int unsigned i = 1; i < CODE_W; i++) begin
      if (in_code[i]) syn_c = syn_c ^ P_W'(i);
    end
    par_c = ^in_code;
  end

  // Correction: only flip when overall parity says a single error and S names a real position.
  always_comb begin
    fixed_c = s1_code;
    hit_c   = 1'b0;
    sec_c   = 1'b0;
    ded_c   = 1'b0;
    for (int unsigned i = 1; i < CODE_W; i++) begin
      if (s1_par && (s1_syn == P_W'(i))) begin
        fixed_c[i] = ~s1_code[i];
        hit_c      = 1'b1;
      end
    end
    if (s1_syn == '0) sec_c = s1_par;
    else if (hit_c)   sec_c = 1'b1;
    else              ded_c = 1'b1;
  end

  for (genvar k = 0; k < DATA_W; k++) begin : g_data
    assign data_c[k] = fixed_c[data_pos(k)];
  end

  // Both stages advance together on en, so a stage-1 bubble is held during a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_par    <= 1'b0;
      s1_syn    <= '0;
      s1_code   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sec   <= 1'b0;
      out_ded   <= 1'b0;
      out_syn   <= '0;
    end else if (en) begin
      s1_valid  <= in_valid;
      if (in_valid) begin
        s1_par  <= par_c;
        s1_syn  <= syn_c;
        s1_code <= in_code;
      end
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= data_c;
        out_sec  <= sec_c;
        out_ded  <= ded_c;
        out_syn  <= s1_syn;
      end
    end
  end

`ifdef HAM_ERR_CNT_EN
  logic xfer;
  assign xfer = out_valid && out_ready;

  // Clear has priority over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      sec_cnt <= '0;
      ded_cnt <= '0;
    end else if (xfer) begin
      if (out_sec && (sec_cnt != '1)) sec_cnt <= sec_cnt + CNT_W'(1);
      if (out_ded && (ded_cnt != '1)) ded_cnt <= ded_cnt + CNT_W'(1);
    end
  end
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign sec_cnt        = '0;
  assign ded_cnt        = '0;
`endif

endmodule

// File: tb/tb_ham_secded_dec.sv
// Scoreboard bench for ham_secded_dec: DATA_W=4/CNT_W=2 main instance plus a DATA_W=5 instance.
module tb_ham_secded_dec;

`ifdef HAM_ERR_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] data;
    logic       sec;
    logic       ded;
    logic [2:0] syn;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_code;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       out_sec;
  logic       out_ded;
  logic [2:0] out_syn;
  logic       cnt_clr;
  logic [1:0] sec_cnt;
  logic [1:0] ded_cnt;

  logic        in_valid5;
  logic        in_ready5;
  logic [9:0]  in_code5;
  logic        out_valid5;
  logic        out_ready5;
  logic [4:0]  out_data5;
  logic        out_sec5;
  logic        out_ded5;
  logic [3:0]  out_syn5;
  logic [15:0] sec_cnt5;
  logic [15:0] ded_cnt5;

  exp_t exp_q[$];
  exp_t exp_cur;
  exp_t got;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  ham_secded_dec #(.DATA_W(4), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sec(out_sec),
    .out_ded(out_ded), .out_syn(out_syn), .cnt_clr(cnt_clr), .sec_cnt(sec_cnt), .ded_cnt(ded_cnt)
  );

  ham_secded_dec #(.DATA_W(5), .CNT_W(16)) dut5 (
    .clk(clk), .rst(rst), .in_valid(in_valid5), .in_ready(in_ready5), .in_code(in_code5),
    .out_valid(out_valid5), .out_ready(out_ready5), .out_data(out_data5), .out_sec(out_sec5),
    .out_ded(out_ded5), .out_syn(out_syn5), .cnt_clr(cnt_clr), .sec_cnt(sec_cnt5), .ded_cnt(ded_cnt5)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] d, input logic s, input logic e, input logic [2:0] y);
    mk = '{data: d, sec: s, ded: e, syn: y};
  endfunction

  // Caller sits just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [7:0] code, input exp_t e);
    int n;
    in_valid = 1'b1;
    in_code  = code;
    exp_cur  = e;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) check("send_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || out_valid) && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic run5(input logic [9:0] code);
    @(posedge clk);
    #1 in_valid5 = 1'b1;
    in_code5 = code;
    @(posedge clk);
    #1 in_valid5 = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Monitor: pop before push so an unexpected output can never match a just-issued word.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", {23'd0, out_data, out_sec, out_ded, out_syn}, 32'h1ff);
        end else begin
          got = exp_q.pop_front();
          check("out_word", {23'd0, out_data, out_sec, out_ded, out_syn}, {23'd0, got});
        end
      end
      if (in_valid && in_ready) exp_q.push_back(exp_cur);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; in_code = '0; out_ready = 1'b1; cnt_clr = 1'b0;
    in_valid5 = 1'b0; in_code5 = '0; out_ready5 = 1'b1; exp_cur = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_out_sec",   32'(out_sec),   32'd0);
    check("rst_out_ded",   32'(out_ded),   32'd0);
    check("rst_out_syn",   32'(out_syn),   32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_sec_cnt",   32'(sec_cnt),   32'd0);
    check("rst_ded_cnt",   32'(ded_cnt),   32'd0);

    // Latency: valid appears two edges after acceptance.
    @(posedge clk); #1;
    send(8'hAA, mk(4'hB, 1'b0, 1'b0, 3'd0));
    @(negedge clk);
    check("lat_edge1_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_edge2_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;

    send(8'h8A, mk(4'hB, 1'b1, 1'b0, 3'd5));
    send(8'hAB, mk(4'hB, 1'b1, 1'b0, 3'd0));
    send(8'hAC, mk(4'hB, 1'b0, 1'b1, 3'd3));
    send(8'h5A, mk(4'h5, 1'b0, 1'b0, 3'd0));
    send(8'h1A, mk(4'h5, 1'b1, 1'b0, 3'd6));
    send(8'h52, mk(4'h5, 1'b1, 1'b0, 3'd3));
    send(8'hCA, mk(4'hD, 1'b0, 1'b1, 3'd3));
    send(8'h00, mk(4'h0, 1'b0, 1'b0, 3'd0));
    send(8'hFF, mk(4'hF, 1'b0, 1'b0, 3'd0));
    send(8'hFE, mk(4'hF, 1'b1, 1'b0, 3'd0));
    send(8'h7F, mk(4'hF, 1'b1, 1'b0, 3'd7));
    drain();

    // Back-to-back burst with a consumer stall in the middle.
    fork
      begin
        send(8'h5A, mk(4'h5, 1'b0, 1'b0, 3'd0));
        send(8'h1A, mk(4'h5, 1'b1, 1'b0, 3'd6));
        send(8'hFF, mk(4'hF, 1'b0, 1'b0, 3'd0));
        send(8'h7F, mk(4'hF, 1'b1, 1'b0, 3'd7));
        send(8'h00, mk(4'h0, 1'b0, 1'b0, 3'd0));
        send(8'hCA, mk(4'hD, 1'b0, 1'b1, 3'd3));
      end
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(negedge clk);
        check("stall_in_ready",  32'(in_ready),  32'd0);
        check("stall_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    check("cnt_sec_sat_pre", 32'(sec_cnt), CNT_ON ? 32'd3 : 32'd0);
    check("cnt_ded_sat_pre", 32'(ded_cnt), CNT_ON ? 32'd3 : 32'd0);
    cnt_clr = 1'b1;
    @(posedge clk);
    #1 cnt_clr = 1'b0;
    send(8'h8A, mk(4'hB, 1'b1, 1'b0, 3'd5));
    send(8'hAB, mk(4'hB, 1'b1, 1'b0, 3'd0));
    send(8'h1A, mk(4'h5, 1'b1, 1'b0, 3'd6));
    send(8'h52, mk(4'h5, 1'b1, 1'b0, 3'd3));
    send(8'hFE, mk(4'hF, 1'b1, 1'b0, 3'd0));
    drain();
    @(negedge clk);
    check("cnt_sec_sat", 32'(sec_cnt), CNT_ON ? 32'd3 : 32'd0);
    check("cnt_ded_zero", 32'(ded_cnt), 32'd0);
    @(posedge clk);
    #1 cnt_clr = 1'b1;
    @(posedge clk);
    #1 cnt_clr = 1'b0;
    @(negedge clk);
    check("cnt_clr_sec", 32'(sec_cnt), 32'd0);
    @(posedge clk); #1;
    send(8'hAC, mk(4'hB, 1'b0, 1'b1, 3'd3));
    drain();
    @(negedge clk);
    check("cnt_ded_one", 32'(ded_cnt), CNT_ON ? 32'd1 : 32'd0);
    check("cnt_sec_still0", 32'(sec_cnt), 32'd0);

    // Clear coinciding with a sec output transfer.
    @(posedge clk);
    #1 out_ready = 1'b0;
    send(8'h8A, mk(4'hB, 1'b1, 1'b0, 3'd5));
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("clr_xfer_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    cnt_clr = 1'b1;
    @(posedge clk);
    #1 cnt_clr = 1'b0;
    @(negedge clk);
    check("clr_wins_sec", 32'(sec_cnt), 32'd0);
    check("clr_wins_ded", 32'(ded_cnt), 32'd0);
    drain();

    // Reset with two words in flight: both must vanish.
    out_ready = 1'b0;
    send(8'h5A, mk(4'h5, 1'b0, 1'b0, 3'd0));
    send(8'h1A, mk(4'h5, 1'b1, 1'b0, 3'd6));
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    check("midrst_no_emit", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    send(8'hAA, mk(4'hB, 1'b0, 1'b0, 3'd0));
    drain();

    // DATA_W=5: S=12 with odd parity names no position.
    run5(10'h111);
    check("w5_valid", 32'(out_valid5), 32'd1);
    check("w5_ded",   32'(out_ded5),   32'd1);
    check("w5_sec",   32'(out_sec5),   32'd0);
    check("w5_syn",   32'(out_syn5),   32'd12);
    check("w5_data",  32'(out_data5),  32'd0);
    run5(10'h319);
    check("w5_fix_data", 32'(out_data5), 32'h15);
    check("w5_fix_sec",  32'(out_sec5),  32'd1);
    check("w5_fix_ded",  32'(out_ded5),  32'd0);
    check("w5_fix_syn",  32'(out_syn5),  32'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
